// File: rtl/multdiv_issue_ctrl_pkg.sv
// rtl/multdiv_issue_ctrl_pkg.sv - shared state encoding and writeback defaults for the multdiv issue path
//
// Holds the issue FSM state type and the default register/exception codes
// that the decode and writeback stages also rely on.
package multdiv_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    localparam int DEF_REG_ADDR_W  = 5;
    localparam int DEF_RSTATUS_REG = 30;
    localparam int DEF_EXC_MULT    = 4;
    localparam int DEF_EXC_DIV     = 5;
    localparam int DEF_TIMEOUT     = 40;

    // Zero-extended $rstatus code for the operation that faulted.
    function automatic logic [31:0] exc_code(input logic is_mult,
                                             input int   exc_mult,
                                             input int   exc_div);
        return is_mult ? 32'(exc_mult) : 32'(exc_div);
    endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_watchdog.sv
// rtl/multdiv_issue_ctrl_watchdog.sv - busy-cycle watchdog counter for the multdiv issue FSM
//
// Ports:
//   clock    - system clock
//   reset    - synchronous active-high reset, clears the counter
//   enable   - high while the FSM is in BUSY; low clears the counter
//   terminal - high during the BUSY cycle in which the count equals TIMEOUT-1
module md_watchdog #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count != CW'(TIMEOUT)) begin
            // Saturate rather than wrap so a stuck enable can never re-arm silently.
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - execute-stage issue/interlock controller for the multi-cycle multiply/divide unit
//
// Ports:
//   clock, reset                  - system clock, synchronous active-high reset
//   ex_valid, ex_is_mult,
//   ex_is_div, ex_opA, ex_opB,
//   ex_rd                         - decoded instruction from the execute stage
//   md_ready, md_result,
//   md_exception                  - completion interface from the multdiv unit
//   md_opA, md_opB                - latched operands held on the unit's inputs
//   md_ctrl_mult, md_ctrl_div     - one-cycle start pulses
//   stall                         - pipeline freeze (combinational)
//   wb_valid, wb_rd, wb_data      - single-cycle writeback, zeroed when not valid
//   timeout_err                   - one-cycle pulse when the watchdog fires
module multdiv_issue_ctrl
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int RSTATUS_REG = DEF_RSTATUS_REG,
    parameter int EXC_MULT    = DEF_EXC_MULT,
    parameter int EXC_DIV     = DEF_EXC_DIV,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_is_mult,
    input  logic                  ex_is_div,
    input  logic [31:0]           ex_opA,
    input  logic [31:0]           ex_opB,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  md_ready,
    input  logic [31:0]           md_result,
    input  logic                  md_exception,
    output logic [31:0]           md_opA,
    output logic [31:0]           md_opB,
    output logic                  md_ctrl_mult,
    output logic                  md_ctrl_div,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [31:0]           wb_data,
    output logic                  timeout_err
);

    md_state_t             state;
    logic                  op_is_mult;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  accept;
    logic                  wd_terminal;
    logic [31:0]           fault_code;

    localparam logic [REG_ADDR_W-1:0] RSTATUS_ADDR = REG_ADDR_W'(RSTATUS_REG);

    assign accept     = (state == ST_IDLE) && ex_valid && (ex_is_mult || ex_is_div);
    // Freeze in the accept cycle itself; release in DONE so the instruction retires.
    assign stall      = accept || (state == ST_START) || (state == ST_BUSY);
    assign fault_code = exc_code(op_is_mult, EXC_MULT, EXC_DIV);

    md_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .enable   (state == ST_BUSY),
        .terminal (wd_terminal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_is_mult   <= 1'b0;
            rd_q         <= '0;
            md_opA       <= '0;
            md_opB       <= '0;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            // Pulse-type outputs default low every cycle.
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            timeout_err  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        md_opA       <= ex_opA;
                        md_opB       <= ex_opB;
                        rd_q         <= ex_rd;
                        // MULT takes priority when decode flags both.
                        op_is_mult   <= ex_is_mult;
                        md_ctrl_mult <= ex_is_mult;
                        md_ctrl_div  <= !ex_is_mult;
                        state        <= ST_START;
                    end
                end

                ST_START: begin
                    // md_ready may still be high from the previous op; do not look at it.
                    state <= ST_BUSY;
                end

                ST_BUSY: begin
                    if (md_ready) begin
                        state <= ST_DONE;
                        if (md_exception) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= RSTATUS_ADDR;
                            wb_data  <= fault_code;
                        end else if (rd_q != '0) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= md_result;
                        end
                    end else if (wd_terminal) begin
                        // Unit never answered: report it as a fault of this op.
                        state       <= ST_DONE;
                        timeout_err <= 1'b1;
                        wb_valid    <= 1'b1;
                        wb_rd       <= RSTATUS_ADDR;
                        wb_data     <= fault_code;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
